instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the opcode decoder in the MIPS-subset CPU.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers fetched words in a 2-entry queue and presents them with a valid/ready handshake.
- Decode consumes instr_o[31:26] as its opcode; branch resolution (beq/bne) redirects fetch through redirect_i.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- imem_req_o  out  1  fetch request; held high until accepted.
- imem_addr_o  out  ADDR_W  word-aligned fetch address; stable while imem_req_o is high.
- imem_ack_i  in  1  memory accept/data-valid; a transfer completes on an edge with req&ack both high.
- imem_data_i  in  INSTR_W  instruction word; valid when imem_ack_i is high.
- instr_valid_o  out  1  queue head valid.
- instr_o  out  INSTR_W  head instruction; 0 when instr_valid_o=0.
- pc_o  out  ADDR_W  head PC; 0 when instr_valid_o=0.
- pc_plus4_o  out  ADDR_W  pc_o+4, modulo 2^ADDR_W; 0 when instr_valid_o=0.
- instr_ready_i  in  1  downstream accepts; pop occurs on an edge with valid&ready.
- redirect_i  in  1  taken-branch redirect, single-cycle.
- redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] forced to 0 internally.

Behaviour:
- Reset (async, immediate): state=IDLE, fetch_pc=RESET_PC, count=0, imem_req_o=0, imem_addr_o=0, instr_valid_o=0, instr_o/pc_o/pc_plus4_o=0.
- State register: IDLE (req=0), BUSY (req=1, addr=fetch_pc), DRAIN (req=1, addr=stale address, returning data discarded).
- Room rule: a new request may start only if count_after_pop + 0 ≤ 1, i.e. at most 2 entries are ever committed including the in-flight one.
- IDLE -> BUSY at an edge when the room rule holds and redirect_i=0. The first edge after rst_i falls enters BUSY, so req is high in cycle 1.
- BUSY, ack=1, no redirect:
  - Push {fetch_pc, imem_data_i}; fetch_pc += 4 (wrap mod 2^ADDR_W).
  - Stay BUSY if the room rule still holds after the push (and any concurrent pop); else go IDLE.
- BUSY, ack=0: hold req and addr unchanged; no deassertion while waiting.
- Throughput: with zero-wait memory (ack tied to req) and ready=1, one instruction per cycle.
- Redirect (redirect_i=1 at an edge) has priority over push and pop:
  - Queue flushed (count=0); fetch_pc=redirect_pc_i&~3. A concurrent valid&ready pop is considered consumed, then flushed.
  - IDLE -> BUSY; the next request uses the redirect address.
  - BUSY with ack=1 -> data discarded -> BUSY with the new address.
  - BUSY with ack=0 -> DRAIN; imem_addr_o keeps the old address.
  - DRAIN with a further redirect -> stay DRAIN, latest target wins.
- DRAIN, ack=1 -> data discarded -> BUSY with fetch_pc. DRAIN, ack=0 -> hold.
- Queue: 2-entry FIFO of {pc, instr}, head at output. Pop and push may occur on the same edge; count is then unchanged. Push never occurs when count=2 (guaranteed by the room rule; assertion in RTL).
- instr_o, pc_o and pc_plus4_o are registered-derived only: no combinational path from any input to any output.
- Reset mid-request: req drops immediately and any ack arriving during reset is ignored. After release, fetch restarts at RESET_PC.

Test Plan:
- Release reset, memory with zero wait, ready=1 -> req high from cycle 1; instr_valid_o high from cycle 2; pc_o = 0,4,8,C,... one per cycle; pc_plus4_o = pc_o+4.
- Zero-wait memory, ready=0 for 6 cycles -> exactly 2 entries held (pc 0, 4); req low once full; ready=1 -> pops 0,4, then fetch resumes at 8 with no skipped or duplicated PC.
- Memory with 3-cycle ack latency; redirect_i to 0x100 one cycle after a req at 0x8 -> addr stays 0x8 until ack; that data is discarded; next req at 0x100; first valid pc_o=0x100.
- Redirect to 0x40 on the same edge as an ack for 0xC, with 1 entry queued -> queue empty next cycle; following req addr 0x40; 0xC never appears on instr_o.
- Redirect_pc_i=0x0000_0043 -> fetch at 0x40. Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; pc_plus4_o = 0 for the first.
- Assert rst_i mid-BUSY while ack is pending -> req, valid and outputs go 0 asynchronously; after release, req at RESET_PC; a stale ack during reset is ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing single-outstanding imem requests into a 2-entry {pc, instr} queue
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, addr_q, addr_n;
  logic [ADDR_W-1:0] q_pc [2];
  logic [INSTR_W-1:0] q_ins [2];
  logic [1:0] cnt, cnt_ap, cnt_n;
  logic hd, tl, valid, pop, push;
  always_comb begin
    valid = cnt != 2'd0;
    pop = valid & instr_ready_i;
    push = state == BUSY && imem_ack_i && !redirect_i;
    tl = hd ^ cnt[0];
    cnt_ap = cnt - {1'b0, pop};
    cnt_n = redirect_i ? 2'd0 : cnt_ap + {1'b0, push};
    fetch_pc_n = redirect_i ? redirect_pc_i & ~ADDR_W'(3) : push ? fetch_pc + ADDR_W'(4) : fetch_pc;
    state_n = state == IDLE ? ((redirect_i || !cnt_ap[1]) ? BUSY : IDLE) :
              state == DRAIN ? (imem_ack_i ? BUSY : DRAIN) :
              imem_ack_i ? (cnt_n[1] ? IDLE : BUSY) : (redirect_i ? DRAIN : BUSY);
    // DRAIN keeps presenting the abandoned address until memory answers it
    addr_n = state_n == BUSY ? fetch_pc_n : state_n == DRAIN ? addr_q : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q <= '0;
      cnt <= '0;
      hd <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q <= addr_n;
      cnt <= cnt_n;
      hd <= redirect_i ? 1'b0 : hd ^ pop;
    end
  always_ff @(posedge clk_i)
    if (push) begin
      q_pc[tl] <= fetch_pc;
      q_ins[tl] <= imem_data_i;
    end
  always_ff @(posedge clk_i)
    if (!rst_i) assert (!(push && cnt == 2'd2));
  assign imem_req_o = state != IDLE;
  assign imem_addr_o = addr_q;
  assign instr_valid_o = valid;
  assign instr_o = valid ? q_ins[hd] : '0;
  assign pc_o = valid ? q_pc[hd] : '0;
  assign pc_plus4_o = valid ? q_pc[hd] + ADDR_W'(4) : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven vectors plus latency/reset sequences against a behavioural imem
module tb_instr_fetch_unit;
  logic clk_i = 1'b0, rst_i = 1'b1, imem_ack_i = 1'b0, instr_ready_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] imem_data_i = '0, redirect_pc_i = '0;
  logic imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, pc_o, pc_plus4_o;
  int checks = 0, failures = 0, lat = 0, wc = 0;
  bit mem_auto = 1'b1;

  instr_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  // memory returns ~addr after lat wait cycles
  initial forever begin
    @(negedge clk_i);
    if (mem_auto) begin
      if (rst_i || !imem_req_o) begin
        imem_ack_i = 1'b0;
        wc = 0;
      end else if (wc >= lat) begin
        imem_ack_i = 1'b1;
        imem_data_i = ~imem_addr_o;
        wc = 0;
      end else begin
        imem_ack_i = 1'b0;
        wc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  typedef struct {
    bit rs; bit rdy; bit rd; logic [31:0] rpc;
    bit req; logic [31:0] addr; bit vld; logic [31:0] pc;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(bit rs, bit rdy, bit rd, logic [31:0] rpc,
                              bit req, logic [31:0] addr, bit vld, logic [31:0] pc);
    vec_t t;
    t.rs = rs; t.rdy = rdy; t.rd = rd; t.rpc = rpc;
    t.req = req; t.addr = addr; t.vld = vld; t.pc = pc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic chk_head(input string nm, input bit vld, input logic [31:0] pc);
    chk({nm, "_valid"}, 32'(instr_valid_o), 32'(vld));
    chk({nm, "_pc"}, pc_o, vld ? pc : 32'h0);
    chk({nm, "_pc4"}, pc_plus4_o, vld ? pc + 32'd4 : 32'h0);
    chk({nm, "_instr"}, instr_o, vld ? ~pc : 32'h0);
  endtask

  initial begin
    int n;
    // zero-wait stream, redirect on an ack edge (0x43 -> 0x40), then wrap redirect
    v.push_back(mk(1,1,0,0,           0,32'h0,0,0));
    v.push_back(mk(0,1,0,0,           1,32'h0,0,0));
    v.push_back(mk(0,1,0,0,           1,32'h4,1,32'h0));
    v.push_back(mk(0,1,0,0,           1,32'h8,1,32'h4));
    v.push_back(mk(0,0,1,32'h43,      1,32'hC,1,32'h8));
    v.push_back(mk(0,1,0,0,           1,32'h40,0,0));
    v.push_back(mk(0,1,1,32'hFFFFFFFC,1,32'h44,1,32'h40));
    v.push_back(mk(0,1,0,0,           1,32'hFFFFFFFC,0,0));
    v.push_back(mk(0,1,0,0,           1,32'h0,1,32'hFFFFFFFC));
    v.push_back(mk(0,1,0,0,           1,32'h4,1,32'h0));
    v.push_back(mk(0,1,0,0,           1,32'h8,1,32'h4));
    // back-pressure: queue fills with 0,4 and fetch stops, then resumes at 8
    v.push_back(mk(1,0,0,0, 0,32'h0,0,0));
    v.push_back(mk(0,0,0,0, 1,32'h0,0,0));
    v.push_back(mk(0,0,0,0, 1,32'h4,1,32'h0));
    v.push_back(mk(0,0,0,0, 0,32'h0,1,32'h0));
    v.push_back(mk(0,0,0,0, 0,32'h0,1,32'h0));
    v.push_back(mk(0,0,0,0, 0,32'h0,1,32'h0));
    v.push_back(mk(0,1,0,0, 0,32'h0,1,32'h0));
    v.push_back(mk(0,1,0,0, 1,32'h8,1,32'h4));
    v.push_back(mk(0,1,0,0, 1,32'hC,1,32'h8));
    v.push_back(mk(0,1,0,0, 1,32'h10,1,32'hC));
    // redirect while IDLE with a full queue
    v.push_back(mk(1,0,0,0,       0,32'h0,0,0));
    v.push_back(mk(0,0,0,0,       1,32'h0,0,0));
    v.push_back(mk(0,0,0,0,       1,32'h4,1,32'h0));
    v.push_back(mk(0,0,1,32'h200, 0,32'h0,1,32'h0));
    v.push_back(mk(0,0,0,0,       1,32'h200,0,0));
    v.push_back(mk(0,0,0,0,       1,32'h204,1,32'h200));

    lat = 0;
    for (int i = 0; i < v.size(); i++) begin
      if (v[i].rs) do_reset();
      else @(negedge clk_i);
      chk($sformatf("row%0d_req", i), 32'(imem_req_o), 32'(v[i].req));
      chk($sformatf("row%0d_addr", i), imem_addr_o, v[i].addr);
      chk_head($sformatf("row%0d", i), v[i].vld, v[i].pc);
      instr_ready_i = v[i].rdy;
      redirect_i = v[i].rd;
      redirect_pc_i = v[i].rpc;
    end

    // 3-cycle memory: redirect while 0x8 is outstanding drains it, then fetches 0x100
    lat = 3;
    instr_ready_i = 1'b1;
    do_reset();
    n = 0;
    while (!(imem_req_o && imem_addr_o == 32'h8) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("lat_wait_addr8", 32'(n < 40), 32'd1);
    @(negedge clk_i);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clk_i);
    redirect_i = 1'b0;
    chk("drain_req", 32'(imem_req_o), 32'd1);
    chk("drain_addr_a", imem_addr_o, 32'h8);
    chk("drain_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    chk("drain_addr_b", imem_addr_o, 32'h8);
    @(negedge clk_i);
    chk("post_drain_addr", imem_addr_o, 32'h100);
    chk("post_drain_valid", 32'(instr_valid_o), 32'd0);
    n = 0;
    while (!instr_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("lat_wait_valid", 32'(n < 20), 32'd1);
    chk_head("redir100", 1'b1, 32'h100);

    // reset mid-request with a pending ack; stale ack during reset must be ignored
    instr_ready_i = 1'b0;
    do_reset();
    n = 0;
    while (!instr_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_wait_valid", 32'(n < 20), 32'd1);
    chk("rst_pre_req", 32'(imem_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_req_o), 32'd0);
    chk("async_rst_addr", imem_addr_o, 32'h0);
    chk_head("async_rst", 1'b0, 32'h0);
    @(negedge clk_i);
    mem_auto = 1'b0;
    imem_ack_i = 1'b1;
    imem_data_i = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk_i);
      chk("in_rst_req", 32'(imem_req_o), 32'd0);
      chk("in_rst_valid", 32'(instr_valid_o), 32'd0);
    end
    imem_ack_i = 1'b0;
    mem_auto = 1'b1;
    rst_i = 1'b0;
    chk("rel_req", 32'(imem_req_o), 32'd0);
    @(negedge clk_i);
    chk("rel_req1", 32'(imem_req_o), 32'd1);
    chk("rel_addr1", imem_addr_o, 32'h0);
    chk("rel_valid1", 32'(instr_valid_o), 32'd0);
    instr_ready_i = 1'b1;
    n = 0;
    while (!instr_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("rel_wait_valid", 32'(n < 20), 32'd1);
    chk_head("rel_first", 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
